// File: rtl/usb_rx_bit_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_bit_timer_pkg
//  Description : Shared USB 1.1 RX timing defaults (oversampling ratio,
//                sample phase, byte length, EOP length) used by the bit
//                timer, the RX shift register and the RCU.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_rx_bit_timer_pkg;

  localparam int c_osr_default           = 8;
  localparam int c_sample_phase_default  = 4;
  localparam int c_bits_per_byte_default = 8;
  localparam int c_eop_bits_default      = 2;

  // Width of a counter that must hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_bit_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_bit_timer_if
//  Description : Line-event inputs and bit/byte/EOP timing outputs of the
//                RX bit timer. The slave side is the timer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface usb_rx_bit_timer_if
  import usb_rx_bit_timer_pkg::*;
#(
  parameter int BITS_PER_BYTE = c_bits_per_byte_default
);

  localparam int c_bcw = $clog2(BITS_PER_BYTE);

  logic             rx_transfer_active;
  logic             edge_det;
  logic             stuff_bit;
  logic             eop_det;
  logic             shift_en;
  logic             byte_received;
  logic [c_bcw-1:0] bit_cnt;
  logic             eop_1_comp;
  logic             eop_comp;
  logic             edge_err;

  modport master (
    output rx_transfer_active, edge_det, stuff_bit, eop_det,
    input  shift_en, byte_received, bit_cnt, eop_1_comp, eop_comp, edge_err
  );

  modport slave (
    input  rx_transfer_active, edge_det, stuff_bit, eop_det,
    output shift_en, byte_received, bit_cnt, eop_1_comp, eop_comp, edge_err
  );

endinterface
`default_nettype wire

// File: rtl/usb_rx_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_bit_timer
//  Description : USB 1.1 RX bit/byte timer. Divides the oversampled clock
//                into bit-sample strobes, re-aligns the sample phase on line
//                transitions, counts non-stuffed bits per byte and times the
//                SE0 end-of-packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_bit_timer
  import usb_rx_bit_timer_pkg::*;
#(
  parameter int OSR           = c_osr_default,
  parameter int SAMPLE_PHASE  = c_sample_phase_default,
  parameter int BITS_PER_BYTE = c_bits_per_byte_default,
  parameter int EOP_BITS      = c_eop_bits_default,
  parameter int RESYNC_EN     = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  usb_rx_bit_timer_if.slave bus
);

  localparam int c_pw  = $clog2(OSR);
  localparam int c_bcw = $clog2(BITS_PER_BYTE);
  localparam int c_ew  = cnt_width(EOP_BITS);

  localparam logic [c_pw-1:0]  c_phase_last   = c_pw'(OSR - 1);
  localparam logic [c_pw-1:0]  c_phase_sample = c_pw'(SAMPLE_PHASE);
  localparam logic [c_pw-1:0]  c_phase_resync = c_pw'(1);
  localparam logic [c_bcw-1:0] c_bit_last     = c_bcw'(BITS_PER_BYTE - 1);
  localparam logic [c_ew-1:0]  c_eop_full     = c_ew'(EOP_BITS);
  localparam logic [c_ew-1:0]  c_eop_last     = c_ew'(EOP_BITS - 1);

  // Reject parameter sets the timer cannot honour.
  generate
    if (OSR < 4) begin : g_chk_osr
      $error("usb_rx_bit_timer: OSR must be at least 4");
    end
    if (SAMPLE_PHASE < 0 || SAMPLE_PHASE >= OSR) begin : g_chk_phase
      $error("usb_rx_bit_timer: SAMPLE_PHASE must lie in 0..OSR-1");
    end
    if (EOP_BITS < 1) begin : g_chk_eop
      $error("usb_rx_bit_timer: EOP_BITS must be at least 1");
    end
    if (BITS_PER_BYTE < 2) begin : g_chk_bpb
      $error("usb_rx_bit_timer: BITS_PER_BYTE must be at least 2");
    end
  endgenerate

  logic [c_pw-1:0]  r_phase;
  logic [c_bcw-1:0] r_bit_cnt;
  logic [c_ew-1:0]  r_eop_cnt;

  // Reset is folded into the qualifier so no output can glitch high while
  // the asynchronous reset is held, even with SAMPLE_PHASE = 0.
  logic w_run;
  logic w_strobe;
  logic w_resync;
  logic w_count;
  logic w_se0;

  assign w_run    = bus.rx_transfer_active & ~rst;
  assign w_strobe = w_run & (r_phase == c_phase_sample);
  assign w_resync = (RESYNC_EN != 0) & bus.edge_det;
  assign w_count  = w_strobe & ~bus.stuff_bit;
  assign w_se0    = w_strobe & bus.eop_det;

  // Phase counter: a transition cycle counts as phase 0, so the next is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
    end else if (!bus.rx_transfer_active) begin
      r_phase <= '0;
    end else if (w_resync) begin
      r_phase <= c_phase_resync;
    end else if (r_phase == c_phase_last) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  // Bit counter: stuffed bits are sampled but not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
    end else if (!bus.rx_transfer_active) begin
      r_bit_cnt <= '0;
    end else if (w_count) begin
      r_bit_cnt <= (r_bit_cnt == c_bit_last) ? '0 : r_bit_cnt + 1'b1;
    end
  end

  // EOP counter: consecutive SE0 samples, saturating until a non-SE0 sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eop_cnt <= '0;
    end else if (!bus.rx_transfer_active) begin
      r_eop_cnt <= '0;
    end else if (w_strobe) begin
      if (!bus.eop_det) begin
        r_eop_cnt <= '0;
      end else if (r_eop_cnt != c_eop_full) begin
        r_eop_cnt <= r_eop_cnt + 1'b1;
      end
    end
  end

  assign bus.shift_en      = w_strobe;
  assign bus.edge_err      = w_strobe & bus.edge_det;
  assign bus.byte_received = w_count & (r_bit_cnt == c_bit_last);
  assign bus.eop_1_comp    = w_se0 & (r_eop_cnt == '0);
  assign bus.eop_comp      = w_se0 & (r_eop_cnt == c_eop_last);
  assign bus.bit_cnt       = w_run ? r_bit_cnt : '0;

endmodule
`default_nettype wire
